// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Purpose  : Round-robin, burst-locking arbiter sharing one FIFO push port
//            between two producers; mirrors FIFO occupancy.
//            Optional per-requester statistics under FIFO_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module fifo_push_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [DATA_WIDTH-1:0]      req0_data,
    input  logic                       req0_last,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [DATA_WIDTH-1:0]      req1_data,
    input  logic                       req1_last,
    output logic                       req1_ready,
    output logic                       push,
    output logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       push_stall,
    input  logic                       pop,
    input  logic                       empty,
    input  logic                       flush,
    output logic [1:0]                 grant,
`ifdef FIFO_ARB_STATS_EN
    output logic [31:0]                stat_beats0,
    output logic [31:0]                stat_beats1,
    output logic [31:0]                stat_stall_cycles,
`endif
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int c_OCC_W = $clog2(DEPTH) + 1;
    localparam int c_CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_prio;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic [c_OCC_W-1:0]   r_occupancy;

    logic                 w_owner;
    logic                 w_owner_vld;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_pop_eff;
    logic [c_CNT_W-1:0]   w_cnt_next;

    // Locked owner wins outright; in IDLE a lone requester wins, ties go to r_prio.
    always_comb begin
        w_owner     = 1'b0;
        w_owner_vld = 1'b0;
        case (r_state)
            ST_LOCK0: begin
                w_owner     = 1'b0;
                w_owner_vld = 1'b1;
            end
            ST_LOCK1: begin
                w_owner     = 1'b1;
                w_owner_vld = 1'b1;
            end
            default: begin
                if (req0_valid && req1_valid) begin
                    w_owner     = r_prio;
                    w_owner_vld = 1'b1;
                end else if (req0_valid) begin
                    w_owner     = 1'b0;
                    w_owner_vld = 1'b1;
                end else if (req1_valid) begin
                    w_owner     = 1'b1;
                    w_owner_vld = 1'b1;
                end
            end
        endcase
    end

    assign w_sel_valid = w_owner ? req1_valid : req0_valid;
    assign w_sel_last  = w_owner ? req1_last  : req0_last;
    assign w_accept    = w_owner_vld & w_sel_valid & ~push_stall & ~flush & ~rst;
    assign w_cnt_next  = r_beat_cnt + c_CNT_W'(1);
    assign w_pop_eff   = pop & ~empty;

    // The first beat is taken in IDLE, so a lock releases once the counter hits MAX_BURST-1.
    assign w_release = w_sel_last |
                       ((r_state == ST_IDLE) ? (MAX_BURST == 1)
                                             : (w_cnt_next == c_CNT_W'(MAX_BURST - 1)));

    assign push       = w_accept;
    assign push_data  = w_owner ? req1_data : req0_data;
    assign req0_ready = w_accept & ~w_owner;
    assign req1_ready = w_accept & w_owner;
    assign grant      = {r_state == ST_LOCK1, r_state == ST_LOCK0};
    assign occupancy  = r_occupancy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prio      <= 1'b0;
            r_beat_cnt  <= '0;
            r_occupancy <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_occupancy <= '0;
        end else begin
            case ({w_accept, w_pop_eff})
                2'b10: if (r_occupancy != c_OCC_W'(DEPTH - 1))
                           r_occupancy <= r_occupancy + c_OCC_W'(1);
                2'b01: if (r_occupancy != '0)
                           r_occupancy <= r_occupancy - c_OCC_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase

            if (w_accept) begin
                if (w_release) begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= '0;
                    r_prio     <= ~w_owner;
                end else begin
                    r_state    <= w_owner ? ST_LOCK1 : ST_LOCK0;
                    r_beat_cnt <= (r_state == ST_IDLE) ? '0 : w_cnt_next;
                end
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [31:0] r_stat_beats0;
    logic [31:0] r_stat_beats1;
    logic [31:0] r_stat_stall;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_beats0 <= '0;
            r_stat_beats1 <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (req0_ready)
                r_stat_beats0 <= r_stat_beats0 + 32'd1;
            if (req1_ready)
                r_stat_beats1 <= r_stat_beats1 + 32'd1;
            if ((req0_valid | req1_valid) & push_stall)
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_beats0       = r_stat_beats0;
    assign stat_beats1       = r_stat_beats1;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Purpose  : Self-checking bench for fifo_push_arbiter (vector table, directed
//            corner sequences, randomized run against a reference model).
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_push_arbiter;

    localparam int DW    = 128;
    localparam int DEPTH = 8;
    localparam int MAXB  = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, req0_valid, req1_valid, req0_last, req1_last;
    logic          push_stall, pop, empty, flush;
    logic [DW-1:0] req0_data, req1_data, push_data;
    logic          req0_ready, req1_ready, push;
    logic [1:0]    grant;
    logic [OW-1:0] occupancy;
`ifdef FIFO_ARB_STATS_EN
    logic [31:0]   stat_beats0, stat_beats1, stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    fifo_push_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .push(push), .push_data(push_data), .push_stall(push_stall),
        .pop(pop), .empty(empty), .flush(flush), .grant(grant),
`ifdef FIFO_ARB_STATS_EN
        .stat_beats0(stat_beats0), .stat_beats1(stat_beats1), .stat_stall_cycles(stat_stall_cycles),
`endif
        .occupancy(occupancy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: owner (-1 = none), beats taken in current grant, priority, FIFO fill.
    int m_owner = -1;
    int m_beats = 0;
    int m_prio  = 0;
    int m_occ   = 0;

    logic          s_push;
    logic [1:0]    s_rdy;
    logic [1:0]    s_grant;
    logic [OW-1:0] s_occ;
    int            last_g;
    bit            last_acc;

    task automatic model_eval(output int g, output bit acc);
        if (m_owner >= 0)                  g = m_owner;
        else if (req0_valid && req1_valid) g = m_prio;
        else if (req0_valid)               g = 0;
        else if (req1_valid)               g = 1;
        else                               g = -1;
        acc = (g >= 0) && ((g == 0) ? req0_valid : req1_valid) && !push_stall && !flush && !rst;
    endtask

    task automatic model_update(input int g, input bit acc);
        int taken;
        bit lst;
        if (rst) begin
            m_owner = -1; m_beats = 0; m_prio = 0; m_occ = 0;
        end else if (flush) begin
            m_owner = -1; m_beats = 0; m_occ = 0;
        end else begin
            m_occ = m_occ + (acc ? 1 : 0) - ((pop && !empty) ? 1 : 0);
            if (acc) begin
                lst   = (g == 1) ? req1_last : req0_last;
                taken = (m_owner < 0) ? 1 : m_beats + 1;
                if (lst || taken >= MAXB) begin
                    m_owner = -1; m_beats = 0; m_prio = 1 - g;
                end else begin
                    m_owner = g; m_beats = taken;
                end
            end
        end
    endtask

    function automatic logic [1:0] model_grant();
        return (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    endfunction

    // One clock: inputs already driven by caller just after the previous edge.
    task automatic tick();
        int g;
        bit acc;
        empty     = (m_occ == 0);
        req0_data = {$urandom, $urandom, $urandom, $urandom};
        req1_data = {$urandom, $urandom, $urandom, $urandom};
        #3;
        model_eval(g, acc);
        s_push = push;
        s_rdy  = {req1_ready, req0_ready};
        chk("push", push, acc);
        chk("ready", {req1_ready, req0_ready}, {acc && g == 1, acc && g == 0});
        if (acc) chk("push_data", push_data, (g == 1) ? req1_data : req0_data);
        @(posedge clk);
        model_update(g, acc);
        #1;
        s_grant = grant;
        s_occ   = occupancy;
        chk("grant", grant, model_grant());
        chk("occupancy", occupancy, m_occ);
        last_g   = g;
        last_acc = acc;
    endtask

    task automatic drive(input bit r, input bit v0, input bit v1, input bit l0, input bit l1,
                         input bit st, input bit p, input bit f);
        rst = r; req0_valid = v0; req1_valid = v1; req0_last = l0; req1_last = l1;
        push_stall = st; pop = p; flush = f;
    endtask

    typedef struct {
        bit       rst, v0, v1, l0, l1, stall, pop, flush;
        bit       exp_push;
        bit [1:0] exp_rdy;
        bit [1:0] exp_grant;
        int       exp_occ;
    } vec_t;

    vec_t tbl[12];
    int   q[$];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        empty = 1; req0_data = '0; req1_data = '0;

        //          rst v0 v1 l0 l1 st pop fl  push rdy    grant  occ
        tbl[0]  = '{1, 1, 1, 1, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0};
        tbl[2]  = '{0, 1, 1, 1, 1, 0, 0, 0,  1, 2'b01, 2'b00, 1};
        tbl[3]  = '{0, 1, 1, 1, 1, 0, 0, 0,  1, 2'b10, 2'b00, 2};
        tbl[4]  = '{0, 1, 1, 1, 1, 0, 0, 0,  1, 2'b01, 2'b00, 3};
        tbl[5]  = '{0, 1, 1, 1, 1, 0, 0, 0,  1, 2'b10, 2'b00, 4};
        tbl[6]  = '{0, 1, 0, 1, 0, 0, 0, 0,  1, 2'b01, 2'b00, 5};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 0,  1, 2'b10, 2'b10, 6};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0};
        tbl[9]  = '{0, 1, 1, 1, 1, 0, 0, 0,  1, 2'b10, 2'b00, 1};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 1, 0,  1, 2'b01, 2'b01, 1};
        tbl[11] = '{0, 1, 0, 1, 0, 0, 0, 0,  1, 2'b01, 2'b00, 2};

        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].l0, tbl[i].l1,
                  tbl[i].stall, tbl[i].pop, tbl[i].flush);
            tick();
            chk($sformatf("tbl%0d_push", i), s_push, tbl[i].exp_push);
            chk($sformatf("tbl%0d_ready", i), s_rdy, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_grant", i), s_grant, tbl[i].exp_grant);
            chk($sformatf("tbl%0d_occ", i), s_occ, tbl[i].exp_occ);
        end

        // Forced release: 6 unterminated beats from req0 against one single beat from req1.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        begin
            int n0 = 0, n1 = 0;
            for (int c = 0; c < 20 && q.size() < 7; c++) begin
                drive(0, n0 < 6, n1 < 1, 0, 1, m_occ == DEPTH - 1, 0, 0);
                tick();
                if (last_acc) begin
                    q.push_back(last_g);
                    if (last_g == 0) n0++; else n1++;
                end
            end
        end
        chk("forced_count", q.size(), 7);
        for (int i = 0; i < q.size() && i < 7; i++)
            chk($sformatf("forced_owner%0d", i), q[i], (i == 4) ? 1 : 0);

        // Full FIFO: blocked, pop coinciding with stall still blocks, accepted next cycle.
        drive(0, 1, 0, 1, 0, m_occ == DEPTH - 1, 0, 0);
        tick();
        chk("full_push", s_push, 0);
        chk("full_ready", s_rdy, 2'b00);
        chk("full_occ", s_occ, 7);
        drive(0, 1, 0, 1, 0, 1, 1, 0);
        tick();
        chk("popstall_push", s_push, 0);
        chk("popstall_occ", s_occ, 6);
        drive(0, 1, 0, 1, 0, m_occ == DEPTH - 1, 0, 0);
        tick();
        chk("after_pop_push", s_push, 1);
        chk("after_pop_ready", s_rdy, 2'b01);
        chk("after_pop_occ", s_occ, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("flush_occ", s_occ, 0);

        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                  ($urandom % 3) == 0, ($urandom % 3) == 0,
                  (m_occ == DEPTH - 1) || (($urandom % 10) == 0),
                  ($urandom % 3) == 0, ($urandom % 32) == 0);
            tick();
        end

`ifdef FIFO_ARB_STATS_EN
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("stat_rst_b0", stat_beats0, 0);
        chk("stat_rst_stall", stat_stall_cycles, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, i < 5, i >= 5, 1, 1, 0, m_occ > 0, 0);
            tick();
        end
        chk("stat_beats0", stat_beats0, 5);
        chk("stat_beats1", stat_beats1, 3);
        chk("stat_stall0", stat_stall_cycles, 0);
        drive(0, 1, 0, 1, 0, 1, 0, 0);
        tick();
        chk("stat_stall1", stat_stall_cycles, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("stat_flush_b0", stat_beats0, 5);
        chk("stat_flush_b1", stat_beats1, 3);
        chk("stat_flush_stall", stat_stall_cycles, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
